// File: rtl/prbs31_checker.sv
`timescale 1ns / 1ps
// prbs31_checker
// Serial PRBS31 (x^31 + x^28 + 1) checker. Self-synchronises to the received
// stream, declares lock after a run of correctly predicted bits, then counts
// bit errors against a free-running local generator. Lock is dropped when
// one observation window collects too many errors.
//
// state  | meaning
// -------+-------------------------------------------------------------------
// SEARCH | shift register loaded from din; counting consecutive good predictions
// LOCKED | generator free-runs on its own prediction; din compared for errors
//
// Ports
//   clk        : clock, all state on rising edge
//   rst_n      : asynchronous active-low reset
//   din_valid  : din is sampled this cycle
//   din        : received serial bit
//   clear      : synchronous clear of err_count (only)
//   locked     : registered, high while LOCKED
//   err_pulse  : registered, one cycle per detected error
//   err_count  : registered saturating error count
module prbs31_checker #(
  parameter int LOCK_COUNT = 64,
  parameter int WINDOW     = 256,
  parameter int LOSS_ERRS  = 16,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EW = $clog2(LOSS_ERRS + 1);

  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
  localparam logic [EW-1:0] ERR_LAST   = EW'(LOSS_ERRS - 1);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  logic [30:0]      r_s;
  logic [4:0]       r_fill;
  logic [MW-1:0]    r_match;
  logic [WW-1:0]    r_win_cnt;
  logic [EW-1:0]    r_win_err;
  logic             r_locked;
  logic             r_err_pulse;
  logic [ERR_W-1:0] r_err_count;

  logic w_pred;
  logic w_qual;
  logic w_err;
  logic w_cnt_sat;

  assign w_pred    = r_s[30] ^ r_s[27];
  // An all-zero register predicts zeros forever, so it must never count as
  // a match; otherwise a stuck-low line would lock.
  assign w_qual    = (r_fill == 5'd31) && (r_s != '0);
  assign w_err     = din_valid && (r_state == LOCKED) && (din != w_pred);
  assign w_cnt_sat = &r_err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SEARCH;
      r_s         <= '0;
      r_fill      <= '0;
      r_match     <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_err;

      // clear beats a simultaneous error; the pulse still fires
      if (clear)
        r_err_count <= '0;
      else if (w_err && !w_cnt_sat)
        r_err_count <= r_err_count + 1'b1;

      if (din_valid) begin
        case (r_state)
          SEARCH: begin
            r_s <= {r_s[29:0], din};
            if (r_fill != 5'd31)
              r_fill <= r_fill + 5'd1;
            if (w_qual && (din == w_pred)) begin
              if (r_match == MATCH_LAST) begin
                r_state   <= LOCKED;
                r_locked  <= 1'b1;
                r_match   <= '0;
                r_win_cnt <= '0;
                r_win_err <= '0;
              end else begin
                r_match <= r_match + 1'b1;
              end
            end else begin
              r_match <= '0;
            end
          end

          LOCKED: begin
            // free-run on the prediction so one bad bit gives one error
            r_s <= {r_s[29:0], w_pred};
            if (w_err && (r_win_err == ERR_LAST)) begin
              // s is kept; the fresh fill forces a full re-acquisition
              r_state  <= SEARCH;
              r_locked <= 1'b0;
              r_fill   <= '0;
              r_match  <= '0;
            end else if (r_win_cnt == WIN_LAST) begin
              r_win_cnt <= '0;
              r_win_err <= '0;
            end else begin
              r_win_cnt <= r_win_cnt + 1'b1;
              if (w_err)
                r_win_err <= r_win_err + 1'b1;
            end
          end

          default: r_state <= SEARCH;
        endcase
      end
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_prbs31_checker.sv
`timescale 1ns / 1ps
// Testbench for prbs31_checker: a default instance and an ERR_W=4 instance
// share one stimulus stream. Expected error events are queued when an
// erroneous bit is driven and popped by a monitor on each err_pulse.
module tb_prbs31_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_valid = 1'b0;
  logic        din = 1'b0;
  logic        clear = 1'b0;
  logic        locked_a, pulse_a, locked_b, pulse_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  prbs31_checker u_dut_a (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clear(clear),
    .locked(locked_a), .err_pulse(pulse_a), .err_count(cnt_a)
  );

  prbs31_checker #(.ERR_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clear(clear),
    .locked(locked_b), .err_pulse(pulse_b), .err_count(cnt_b)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [3:0]  b;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [15:0] exp_a = '0;
  logic [3:0]  exp_b = '0;
  logic [30:0] g;
  int          n_checks = 0;
  int          n_fail = 0;
  int          pulses_b = 0;
  int          lock_bits = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic gen(output logic b);
    b = g[30] ^ g[27];
    g = {g[29:0], b};
  endtask

  task automatic send(input logic b, input logic err, input logic clr);
    @(negedge clk);
    din_valid = 1'b1;
    din       = b;
    clear     = clr;
    if (clr) begin
      exp_a = '0;
      exp_b = '0;
    end
    if (err) begin
      if (!clr) begin
        if (exp_a != 16'hFFFF) exp_a = exp_a + 16'd1;
        if (exp_b != 4'hF)     exp_b = exp_b + 4'd1;
      end
      sb_q.push_back({exp_a, exp_b});
    end
    lock_bits++;
  endtask

  task automatic settle();
    @(negedge clk);
    din_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic prbs(input int n, input int gap_pct);
    logic b;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 3 && gap_pct > 0 && $urandom_range(99) < gap_pct; k++) begin
        @(negedge clk);
        din_valid = 1'b0;
      end
      gen(b);
      send(b, 1'b0, 1'b0);
    end
  endtask

  task automatic err_bit(input logic clr);
    logic b;
    gen(b);
    send(~b, 1'b1, clr);
  endtask

  task automatic do_clear();
    @(negedge clk);
    din_valid = 1'b0;
    clear     = 1'b1;
    exp_a     = '0;
    exp_b     = '0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && (pulse_a || pulse_b)) begin
      if (pulse_b) pulses_b++;
      chk("pulse_pair", {31'd0, pulse_b}, {31'd0, pulse_a});
      chk("pulse_expected", {31'd0, sb_q.size() > 0}, 32'd1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("err_count_a", {16'd0, cnt_a}, {16'd0, mon_e.a});
        chk("err_count_b", {28'd0, cnt_b}, {28'd0, mon_e.b});
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int n;
    logic saw_lock;

    // reset state
    g = 31'h7FFFFFFF;
    repeat (3) @(negedge clk);
    chk("rst_locked", {31'd0, locked_a}, 32'd0);
    chk("rst_pulse", {31'd0, pulse_a}, 32'd0);
    chk("rst_count_a", {16'd0, cnt_a}, 32'd0);
    chk("rst_count_b", {28'd0, cnt_b}, 32'd0);
    rst_n = 1'b1;

    // exact lock latency on a clean stream
    prbs(94, 0);
    settle();
    chk("no_lock_at_94", {31'd0, locked_a}, 32'd0);
    prbs(1, 0);
    settle();
    chk("lock_at_95", {31'd0, locked_a}, 32'd1);
    chk("lock_at_95_b", {31'd0, locked_b}, 32'd1);
    lock_bits = 0;

    prbs(10000, 0);
    settle();
    chk("clean_count", {16'd0, cnt_a}, 32'd0);
    chk("clean_locked", {31'd0, locked_a}, 32'd1);

    // single inverted bit
    err_bit(1'b0);
    prbs(300, 0);
    settle();
    chk("single_err_count", {16'd0, cnt_a}, 32'd1);
    chk("single_err_locked", {31'd0, locked_a}, 32'd1);
    chk("single_err_drained", sb_q.size(), 32'd0);

    // clear alone leaves lock intact
    do_clear();
    settle();
    chk("clear_count", {16'd0, cnt_a}, 32'd0);
    chk("clear_locked", {31'd0, locked_a}, 32'd1);

    // 16 errors in one window: loss on the 16th
    prbs((256 - (lock_bits % 256)) % 256, 0);
    for (int k = 0; k < 16; k++) begin
      err_bit(1'b0);
      if (k == 14) begin
        settle();
        chk("hold_at_15", {31'd0, locked_a}, 32'd1);
      end
      if (k < 15) prbs(7, 0);
    end
    settle();
    chk("loss_after_16", {31'd0, locked_a}, 32'd0);
    chk("loss_count_a", {16'd0, cnt_a}, 32'd16);
    chk("loss_count_b", {28'd0, cnt_b}, 32'd15);

    // fresh 95 bits to re-lock
    prbs(94, 0);
    settle();
    chk("relock_not_94", {31'd0, locked_a}, 32'd0);
    prbs(1, 0);
    settle();
    chk("relock_95", {31'd0, locked_a}, 32'd1);
    lock_bits = 0;

    // 15 errors per window over three windows holds lock
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < 256; i++)
        if ((i % 16 == 0) && (i < 240)) err_bit(1'b0);
        else prbs(1, 0);
    settle();
    chk("hold_15_per_win", {31'd0, locked_a}, 32'd1);
    chk("hold_count_a", {16'd0, cnt_a}, 32'd61);
    chk("hold_count_b", {28'd0, cnt_b}, 32'd15);
    chk("hold_drained", sb_q.size(), 32'd0);

    // saturation of the 4-bit counter
    do_clear();
    p0 = pulses_b;
    for (int k = 0; k < 20; k++) begin
      err_bit(1'b0);
      prbs(19, 0);
    end
    settle();
    chk("sat_pulses", pulses_b - p0, 32'd20);
    chk("sat_count_b", {28'd0, cnt_b}, 32'd15);
    chk("sat_count_a", {16'd0, cnt_a}, 32'd20);
    chk("sat_locked", {31'd0, locked_a}, 32'd1);

    // clear together with an error
    err_bit(1'b1);
    settle();
    chk("clr_err_count_a", {16'd0, cnt_a}, 32'd0);
    chk("clr_err_count_b", {28'd0, cnt_b}, 32'd0);

    // asynchronous reset mid-lock with errors in the window
    err_bit(1'b0);
    prbs(5, 0);
    err_bit(1'b0);
    prbs(5, 0);
    err_bit(1'b0);
    settle();
    chk("pulse_before_rst", {31'd0, pulse_a}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_locked", {31'd0, locked_a}, 32'd0);
    chk("arst_pulse", {31'd0, pulse_a}, 32'd0);
    chk("arst_count_a", {16'd0, cnt_a}, 32'd0);
    chk("arst_count_b", {28'd0, cnt_b}, 32'd0);
    chk("arst_drained", sb_q.size(), 32'd0);
    sb_q.delete();
    exp_a = '0;
    exp_b = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // gaps stretch time but not bit count
    g = 31'h7FFFFFFF;
    prbs(94, 30);
    settle();
    chk("gap_no_lock_94", {31'd0, locked_a}, 32'd0);
    prbs(1, 30);
    settle();
    chk("gap_lock_95", {31'd0, locked_a}, 32'd1);

    // stuck-low line never locks
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    saw_lock = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      send(1'b0, 1'b0, 1'b0);
      if (locked_a) saw_lock = 1'b1;
    end
    settle();
    chk("stuck_low_no_lock", {31'd0, saw_lock | locked_a}, 32'd0);
    chk("stuck_low_count", {16'd0, cnt_a}, 32'd0);

    g = 31'h7FFFFFFF;
    n = 0;
    while (!locked_a && n < 95) begin
      prbs(1, 0);
      settle();
      n++;
    end
    chk("after_low_lock", {31'd0, locked_a}, 32'd1);
    prbs(500, 0);
    settle();
    chk("after_low_clean", {16'd0, cnt_a}, 32'd0);
    chk("final_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs31_checker.md
# prbs31_checker

Serial PRBS31 (x^31 + x^28 + 1) checker. It sits directly downstream of the PRBS31 pattern path in the tile and consumes one received bit per valid cycle. It self-synchronises to the incoming stream, declares lock, and from then on counts bit errors against a locally regenerated sequence. Lock is dropped automatically when the error density gets too high.

## Interface
Parameters:
- LOCK_COUNT, 64: consecutive matching bits required to declare lock (1..1023).
- WINDOW, 256: bits per loss-of-lock observation window (2..1024).
- LOSS_ERRS, 16: errors within one window that force loss of lock (1..WINDOW).
- ERR_W, 16: width of the saturating error counter.

Ports:
- clk, input, 1: single clock; all state on rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- din_valid, input, 1: din is sampled this cycle.
- din, input, 1: received serial bit.
- clear, input, 1: synchronous clear of err_count.
- locked, output, 1: registered; 1 while in LOCKED.
- err_pulse, output, 1: registered; 1 for one cycle per detected error.
- err_count, output, ERR_W: registered saturating error count.

## Operation
- State: 31-bit shift register s (s[0] newest). prediction p = s[30] ^ s[27]. Shift: s <= {s[29:0], b}.
- Two-state FSM, SEARCH and LOCKED. Reset state is SEARCH.
- SEARCH, on each din_valid:
  - b = din, so the register is loaded from the received stream.
  - fill counter saturates at 31.
  - A bit is qualified only when fill == 31 and s != 0. An all-zero register never qualifies, which prevents false lock on a stuck-low line.
  - Qualified match: match_cnt++.
  - Qualified mismatch or unqualified bit: match_cnt <= 0.
  - When a match brings match_cnt to LOCK_COUNT: go to LOCKED, clear window counters.
- LOCKED, on each din_valid:
  - b = p, so the generator free-runs and errors do not multiply.
  - din != p is an error. Each error sets err_pulse, increments err_count (saturating at all ones) and increments win_err.
  - win_cnt counts valid bits 0..WINDOW-1. At wrap, win_cnt and win_err both reset to 0.
  - If an error brings win_err to LOSS_ERRS: go to SEARCH; fill and match_cnt reset to 0; s keeps its contents.
- clear clears err_count only. It does not affect FSM, lock or window state.
- clear in the same cycle as an error: clear wins and err_count becomes 0. err_pulse still asserts.
- din_valid = 0: no state changes except clear; err_pulse = 0.
- Reset values, for any reset including mid-stream: locked = 0, err_pulse = 0, err_count = 0, s = 0, all counters 0, FSM = SEARCH.

## Timing
- All outputs are registered, with no combinational path from input to output.
- err_pulse is high in the cycle after the clock edge that sampled the erroneous bit, for exactly one cycle per error.
- Lock latency on a clean stream from reset: 31 fill bits plus LOCK_COUNT matching bits. locked rises the cycle after the edge that samples valid bit number 31+LOCK_COUNT. Gaps in din_valid stretch this time but not the bit count.
- Loss latency: locked falls the cycle after the edge that samples the LOSS_ERRS-th error of a window. That error is still counted and pulsed.
- Re-lock after loss needs a fresh 31 + LOCK_COUNT valid bits.
- err_count updates on the same edge that raises err_pulse.
- err_count saturates: at all ones, further errors leave it unchanged while err_pulse still fires.

## Test plan
- Clean stream from a generator seeded 0x7FFFFFFF, continuous valid -> locked = 1 after exactly 31+64 = 95 bits; err_count stays 0 over 10,000 further bits.
- Once locked, invert a single bit -> exactly one err_pulse, err_count = 1, locked stays 1, no follow-on errors.
- din held at 0 for 5,000 valid cycles -> locked never asserts and err_count = 0. Then switch to a clean PRBS -> locks within 95 bits.
- Once locked, inject 16 errors within one 256-bit window -> 16 pulses, err_count = 16, locked falls the cycle after the 16th error. Then 15 errors per window on a clean stream -> lock held.
- ERR_W = 4, 20 errors spread across windows -> err_count stops at 15 and err_pulse still fires 20 times. Assert clear together with an error -> err_count = 0.
- Deassert rst_n mid-lock while a window holds errors -> all outputs 0 immediately (asynchronous). After release, lock takes 95 bits again; random din_valid gaps do not change the bit count to lock.
